// File: rtl/risc16_mem_arb.sv
// Two-master arbiter for a single-port, byte-laned 16-bit data memory.
// Serialises core (m0) and host (m1) accesses; read data returns with a valid pulse.
module risc16_mem_arb #(
    parameter int RD_LAT = 2,
    parameter bit ARB_RR = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req,
    input  logic [15:0] m0_addr,
    input  logic [15:0] m0_wdata,
    input  logic [1:0]  m0_we,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [15:0] m0_rdata,
    input  logic        m1_req,
    input  logic [15:0] m1_addr,
    input  logic [15:0] m1_wdata,
    input  logic [1:0]  m1_we,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [15:0] m1_rdata,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_we1,
    output logic        mem_we0,
    output logic        mem_oe,
    input  logic [15:0] mem_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    // WAIT occupies RD_LAT-1 cycles, so the counter stops at RD_LAT-2
    localparam logic [1:0] WAIT_END = (RD_LAT > 1) ? 2'(RD_LAT - 2) : 2'd0;

    state_t     state;
    logic [1:0] cnt;
    logic       last;
    logic       win;
    logic       rd;
    logic       any_req;
    logic       pick;

    always_comb begin
        any_req = m0_req | m1_req;
        pick    = 1'b0;
        if (m0_req && m1_req)
            pick = ARB_RR ? ~last : 1'b0;
        else if (m1_req)
            pick = 1'b1;
    end

    // Command registers double as the memory-side outputs, loaded on the IDLE->CMD edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 2'd0;
            last      <= 1'b1;
            win       <= 1'b0;
            rd        <= 1'b0;
            m0_gnt    <= 1'b0;
            m1_gnt    <= 1'b0;
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            m0_rdata  <= 16'h0;
            m1_rdata  <= 16'h0;
            mem_addr  <= 16'h0;
            mem_wdata <= 16'h0;
            mem_we1   <= 1'b0;
            mem_we0   <= 1'b0;
            mem_oe    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            m0_gnt    <= 1'b0;
            m1_gnt    <= 1'b0;
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            mem_we1   <= 1'b0;
            mem_we0   <= 1'b0;
            mem_oe    <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        win   <= pick;
                        state <= CMD;
                        busy  <= 1'b1;
                        if (pick) begin
                            mem_addr  <= m1_addr;
                            mem_wdata <= m1_wdata;
                            mem_we1   <= m1_we[1];
                            mem_we0   <= m1_we[0];
                            mem_oe    <= (m1_we == 2'b00);
                            rd        <= (m1_we == 2'b00);
                            m1_gnt    <= 1'b1;
                        end else begin
                            mem_addr  <= m0_addr;
                            mem_wdata <= m0_wdata;
                            mem_we1   <= m0_we[1];
                            mem_we0   <= m0_we[0];
                            mem_oe    <= (m0_we == 2'b00);
                            rd        <= (m0_we == 2'b00);
                            m0_gnt    <= 1'b1;
                        end
                    end
                end
                CMD: begin
                    last <= win;
                    if (rd) begin
                        if (RD_LAT > 1) begin
                            state <= WAIT;
                            cnt   <= 2'd0;
                        end else begin
                            state <= DONE;
                        end
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                WAIT: begin
                    if (cnt == WAIT_END) begin
                        state <= DONE;
                        cnt   <= 2'd0;
                    end else begin
                        cnt <= cnt + 2'd1;
                    end
                end
                DONE: begin
                    if (win) begin
                        m1_rdata  <= mem_rdata;
                        m1_rvalid <= 1'b1;
                    end else begin
                        m0_rdata  <= mem_rdata;
                        m0_rvalid <= 1'b1;
                    end
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
